// File: rtl/bnn_pkg.sv
// Shared types and constants for the binary-neuron scheduler: FSM state
// encoding, default datapath geometry and a saturating adder.
package bnn_pkg;

    localparam int N_DEF       = 256;
    localparam int ADDR_W_DEF  = 3;
    localparam int POP_DEF     = 16;
    localparam int RD_LAT_DEF  = 2;
    localparam int POP_LAT_DEF = 2;

    localparam int LAT      = RD_LAT_DEF + POP_LAT_DEF;
    localparam int POP_W_IN = $clog2(N_DEF) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CMP,
        OUT
    } state_t;

    // Adds two unsigned values and clamps the result to a width-bit all-ones maximum.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] s;
        logic [32:0] max_v;
        s     = {1'b0, a} + {1'b0, b};
        max_v = (33'd1 << width) - 33'd1;
        return (s > max_v) ? max_v[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/bnn_valid_pipe.sv
// In-flight tracker: a DEPTH-deep 1-bit shift register whose tail marks the
// cycle a chunk's popcount arrives back from the datapath.
module bnn_valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    output logic tail,
    output logic last_only
);

    logic [DEPTH-1:0] sr;

    // last_only means nothing is in flight except possibly the chunk at the tail.
    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or posedge rstn) begin
                if (rstn) sr <= '0;
                else      sr <= push;
            end
            assign last_only = 1'b1;
        end else begin : g_multi
            always_ff @(posedge clk or posedge rstn) begin
                if (rstn) sr <= '0;
                else      sr <= {sr[DEPTH-2:0], push};
            end
            assign last_only = ~|sr[DEPTH-2:0];
        end
    endgenerate

    assign tail = sr[DEPTH-1];

endmodule

// File: rtl/bnn_neuron_sched.sv
// Binary-neuron evaluation sequencer: issues chunk reads, accumulates returned
// popcounts, compares against the threshold. Optional port: BNN_SCHED_SUM_OUT_EN.
module bnn_neuron_sched
    import bnn_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int POP     = POP_DEF,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int POP_LAT = POP_LAT_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W:0]   num_chunks,
    input  logic [POP-1:0]    threshold,
    output logic              busy,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [$clog2(N):0] pop_in,
    output logic              result,
    output logic              result_valid,
    input  logic              result_ready
`ifdef BNN_SCHED_SUM_OUT_EN
    ,
    output logic [POP-1:0]    result_sum
`endif
);

    localparam int PIPE_LAT = RD_LAT + POP_LAT;
    localparam logic [ADDR_W:0] MAX_CHUNKS = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE        = (ADDR_W + 1)'(1);

    state_t state;
    state_t state_nxt;

    logic [ADDR_W:0] chunks;
    logic [ADDR_W:0] chunks_clamped;
    logic [ADDR_W:0] issue_cnt;
    logic [POP-1:0]  thr;
    logic [POP-1:0]  sum;
    logic            accept;
    logic            last_issue;
    logic            pipe_tail;
    logic            pipe_last_only;

    assign chunks_clamped = (num_chunks > MAX_CHUNKS) ? MAX_CHUNKS : num_chunks;
    assign accept         = (state == IDLE) && start;
    assign last_issue     = ((issue_cnt + ONE) == chunks);

    bnn_valid_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_valid_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .push      (mem_re),
        .tail      (pipe_tail),
        .last_only (pipe_last_only)
    );

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state <= IDLE;
        else      state <= state_nxt;
    end

    // Drain ends once only the tail chunk can still be pending, so CMP sees the final sum.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (num_chunks == '0) ? CMP : ISSUE;
            ISSUE: if (last_issue) state_nxt = DRAIN;
            DRAIN: if (pipe_last_only) state_nxt = CMP;
            CMP:   state_nxt = OUT;
            OUT:   if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state != IDLE);
        mem_re       = 1'b0;
        mem_addr     = '0;
        result_valid = (state == OUT);
        if (state == ISSUE) begin
            mem_re   = 1'b1;
            mem_addr = issue_cnt[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            chunks    <= '0;
            thr       <= '0;
            issue_cnt <= '0;
            result    <= 1'b0;
        end else begin
            if (accept) begin
                chunks    <= chunks_clamped;
                thr       <= threshold;
                issue_cnt <= '0;
            end else if (state == ISSUE) begin
                issue_cnt <= issue_cnt + ONE;
            end
            if (state == CMP) result <= (sum > thr);
        end
    end

    // Returns are accumulated whenever the tail says one is due, independent of state.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)           sum <= '0;
        else if (accept)    sum <= '0;
        else if (pipe_tail) sum <= POP'(sat_add(32'(sum), 32'(pop_in), POP));
    end

`ifdef BNN_SCHED_SUM_OUT_EN
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)               result_sum <= '0;
        else if (state == CMP)  result_sum <= sum;
    end
`endif

endmodule

// File: tb/tb_bnn_neuron_sched.sv
// Self-checking bench for bnn_neuron_sched: a POP=16 and a POP=11 instance
// share stimulus; a behavioural datapath returns popcounts LAT cycles after issue.
module tb_bnn_neuron_sched;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [3:0]  num_chunks;
    logic [15:0] threshold;
    logic [10:0] threshold_11;
    logic [8:0]  pop_in = '0;
    logic        result_ready;

    logic        busy, mem_re, result, result_valid;
    logic [2:0]  mem_addr;
    logic        busy_11, mem_re_11, result_11, result_valid_11;
    logic [2:0]  mem_addr_11;
`ifdef BNN_SCHED_SUM_OUT_EN
    logic [15:0] result_sum;
    logic [10:0] result_sum_11;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops[8];
    int pop_sched[int];
    int addr_q[$];
    int acyc_q[$];

    assign threshold_11 = threshold[10:0];

    bnn_neuron_sched #(.POP(16)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .num_chunks   (num_chunks),
        .threshold    (threshold),
        .busy         (busy),
        .mem_re       (mem_re),
        .mem_addr     (mem_addr),
        .pop_in       (pop_in),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
`ifdef BNN_SCHED_SUM_OUT_EN
        ,
        .result_sum   (result_sum)
`endif
    );

    bnn_neuron_sched #(.POP(11)) dut11 (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .num_chunks   (num_chunks),
        .threshold    (threshold_11),
        .busy         (busy_11),
        .mem_re       (mem_re_11),
        .mem_addr     (mem_addr_11),
        .pop_in       (pop_in),
        .result       (result_11),
        .result_valid (result_valid_11),
        .result_ready (result_ready)
`ifdef BNN_SCHED_SUM_OUT_EN
        ,
        .result_sum   (result_sum_11)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer + popcount model: a read issued in cycle c returns its popcount in cycle c+LAT;
    // all other cycles carry random garbage that must be ignored.
    always @(negedge clk) begin
        if (mem_re) begin
            pop_sched[cyc + LAT] = pops[mem_addr];
            addr_q.push_back(int'(mem_addr));
            acyc_q.push_back(cyc);
        end
        if (pop_sched.exists(cyc)) pop_in = 9'(pop_sched[cyc]);
        else                       pop_in = 9'($urandom_range(0, 256));
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // pop_mode: -1 random pops, -2 keep preset pops, otherwise a constant pop value.
    task automatic applyStimulus(input int n, input int thr, input int pop_mode);
        int n_eff, total, exp16, exp11, lat, s, w;
        n_eff = (n > 8) ? 8 : n;
        total = 0;
        for (int k = 0; k < 8; k++) begin
            if (pop_mode == -1)      pops[k] = $urandom_range(0, 256);
            else if (pop_mode != -2) pops[k] = pop_mode;
        end
        for (int k = 0; k < n_eff; k++) total += pops[k];
        exp16 = (total > 65535) ? 65535 : total;
        exp11 = (total > 2047) ? 2047 : total;
        lat   = (n_eff == 0) ? 2 : 1 + n_eff + LAT + 1;
        addr_q.delete();
        acyc_q.delete();
        @(negedge clk);
        start      = 1'b1;
        num_chunks = 4'(n);
        threshold  = 16'(thr);
        s          = cyc;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!result_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        checkOutput("valid", result_valid, 1);
        checkOutput("valid11", result_valid_11, 1);
        checkOutput("latency", cyc - s, lat);
        checkOutput("result", result, (exp16 > thr) ? 1 : 0);
        checkOutput("result11", result_11, (exp11 > (thr & 2047)) ? 1 : 0);
`ifdef BNN_SCHED_SUM_OUT_EN
        checkOutput("sum", result_sum, exp16);
        checkOutput("sum11", result_sum_11, exp11);
`endif
        checkOutput("num_addr", addr_q.size(), n_eff);
        for (int k = 0; k < addr_q.size() && k < n_eff; k++) begin
            checkOutput("addr", addr_q[k], k);
            checkOutput("addr_cycle", acyc_q[k] - s, 1 + k);
        end
        @(negedge clk);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_valid", result_valid, 0);
    endtask

    initial begin
        int s, w, total, exp_res;
        rstn         = 1'b1;
        start        = 1'b0;
        num_chunks   = '0;
        threshold    = '0;
        result_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_mem_re", mem_re, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_valid", result_valid, 0);
        rstn = 1'b0;
        @(negedge clk);

        $display("[TB] three chunks, sum above threshold");
        pops = '{100, 150, 100, 0, 0, 0, 0, 0};
        applyStimulus(3, 300, -2);

        $display("[TB] sum equal to threshold");
        pops = '{100, 100, 0, 0, 0, 0, 0, 0};
        applyStimulus(2, 200, -2);

        $display("[TB] zero chunks");
        applyStimulus(0, 0, -1);

        $display("[TB] back-pressure and ignored starts");
        for (int k = 0; k < 8; k++) pops[k] = $urandom_range(0, 256);
        total = pops[0] + pops[1] + pops[2] + pops[3];
        exp_res = (total > 10) ? 1 : 0;
        addr_q.delete();
        acyc_q.delete();
        result_ready = 1'b0;
        @(negedge clk);
        start = 1'b1; num_chunks = 4'd4; threshold = 16'd10; s = cyc;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; num_chunks = 4'd1; threshold = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!result_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        checkOutput("bp_valid", result_valid, 1);
        checkOutput("bp_latency", cyc - s, 10);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid", result_valid, 1);
            checkOutput("bp_hold_busy", busy, 1);
            checkOutput("bp_hold_result", result, exp_res);
            start = (i == 1);
            num_chunks = 4'd0;
            @(negedge clk);
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", result_valid, 0);
        checkOutput("bp_release_busy", busy, 0);
        checkOutput("bp_num_addr", addr_q.size(), 4);
        for (int k = 0; k < addr_q.size() && k < 4; k++) checkOutput("bp_addr", addr_q[k], k);

        $display("[TB] full neuron, saturation boundary");
        applyStimulus(8, 65535, 256);
        applyStimulus(8, 2046, 256);

        $display("[TB] chunk count clamp");
        applyStimulus(15, 500, -1);

        $display("[TB] reset during drain");
        pops = '{200, 200, 0, 0, 0, 0, 0, 0};
        @(negedge clk);
        start = 1'b1; num_chunks = 4'd2; threshold = 16'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("drain_busy", busy, 1);
        rstn = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_mem_re", mem_re, 0);
        checkOutput("abort_mem_addr", mem_addr, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_valid", result_valid, 0);
        @(negedge clk);
        rstn = 1'b0;
        applyStimulus(1, 50, 50);

        $display("[TB] random evaluations");
        for (int r = 0; r < 12; r++) begin
            applyStimulus($urandom_range(0, 9), $urandom_range(0, 1200), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
